// File: rtl/mac_pkg.sv
// Shared FP16 constants and the packed result type for the MAC result packing stage.
package mac_pkg;

  localparam int FP16_BIAS = 15;
  localparam int EXP_MAX   = 31;

  localparam logic [14:0] FP16_INF    = 15'h7C00;
  localparam logic [14:0] FP16_MAXFIN = 15'h7BFF;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

endpackage

// File: rtl/mac_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module mac_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mac_result_pack.sv
// Final FP16 pack stage: exponent adjust, overflow/underflow classification, 2-stage valid/ready pipe.
// Build option MAC_PACK_SATURATE_EN: overflow packs to max finite instead of infinity.
module mac_result_pack
  import mac_pkg::*;
#(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [EXP_W-1:0]  i_max_exp,
  input  logic [MANT_W:0]   i_norm_mant,
  input  logic [4:0]        i_exp_diff,
  input  logic              i_exp_carry,
  input  logic              i_sign,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [15:0]       o_result,
  output logic              o_overflow,
  output logic              o_underflow,
  output logic [CNT_W-1:0]  o_ovf_cnt,
  output logic [CNT_W-1:0]  o_udf_cnt
);

  localparam int E_W = EXP_W + 2;

  function automatic fp16_t pack_ovf(input logic sign);
`ifdef MAC_PACK_SATURATE_EN
    return {sign, FP16_MAXFIN};
`else
    return {sign, FP16_INF};
`endif
  endfunction

  logic                  w_s1_en, w_s2_en;
  logic signed [E_W-1:0] w_e_p0;

  logic                  r_vld_p1;
  logic signed [E_W-1:0] r_e_p1;
  logic                  r_zero_p1;
  logic [MANT_W-1:0]     r_mant_p1;
  logic                  r_sign_p1;

  fp16_t                 w_pack_p1;
  logic                  w_ovf_p1, w_udf_p1;

  logic                  r_vld_p2;
  logic [15:0]           r_result_p2;
  logic                  r_ovf_p2, r_udf_p2;

  // A stage may load when it is empty or its contents move on this cycle.
  assign w_s2_en = !r_vld_p2 || i_ready;
  assign w_s1_en = !r_vld_p1 || w_s2_en;
  assign o_ready = w_s1_en;

  assign w_e_p0 = $signed({{(E_W-EXP_W){1'b0}}, i_max_exp})
                + $signed({{(E_W-5){i_exp_diff[4]}}, i_exp_diff})
                + $signed({{(E_W-1){1'b0}}, i_exp_carry});

  // ---- stage p1: exponent adjust ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_p1 <= 1'b0;
    end else if (w_s1_en) begin
      r_vld_p1 <= i_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_s1_en && i_valid) begin
      r_e_p1    <= w_e_p0;
      r_zero_p1 <= (i_norm_mant == '0);
      r_mant_p1 <= i_norm_mant[MANT_W-1:0];
      r_sign_p1 <= i_sign;
    end
  end

  always_comb begin
    w_pack_p1 = '0;
    w_ovf_p1  = 1'b0;
    w_udf_p1  = 1'b0;
    if (r_zero_p1) begin
      w_pack_p1 = {r_sign_p1, 15'h0000};
    end else if (r_e_p1 >= E_W'(EXP_MAX)) begin
      w_pack_p1 = pack_ovf(r_sign_p1);
      w_ovf_p1  = 1'b1;
    end else if (r_e_p1[E_W-1] || (r_e_p1 == '0)) begin
      w_pack_p1 = {r_sign_p1, 15'h0000};
      w_udf_p1  = 1'b1;
    end else begin
      w_pack_p1 = {r_sign_p1, r_e_p1[EXP_W-1:0], r_mant_p1};
    end
  end

  // ---- stage p2: classified, packed output ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_p2    <= 1'b0;
      r_result_p2 <= 16'h0000;
      r_ovf_p2    <= 1'b0;
      r_udf_p2    <= 1'b0;
    end else if (w_s2_en) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_result_p2 <= w_pack_p1;
        r_ovf_p2    <= w_ovf_p1;
        r_udf_p2    <= w_udf_p1;
      end
    end
  end

  assign o_valid     = r_vld_p2;
  assign o_result    = r_result_p2;
  assign o_overflow  = r_ovf_p2;
  assign o_underflow = r_udf_p2;

  mac_sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (r_vld_p2 && i_ready && r_ovf_p2),
    .o_cnt   (o_ovf_cnt)
  );

  mac_sat_counter #(.CNT_W(CNT_W)) u_udf_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (r_vld_p2 && i_ready && r_udf_p2),
    .o_cnt   (o_udf_cnt)
  );

endmodule

// File: tb/tb_mac_result_pack.sv
// Directed bench for mac_result_pack: packing, flags, back-pressure, reset and counter saturation.
module tb_mac_result_pack;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_max_exp;
  logic [10:0] i_norm_mant;
  logic [4:0]  i_exp_diff;
  logic        i_exp_carry;
  logic        i_sign;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_result;
  logic        o_overflow;
  logic        o_underflow;
  logic [7:0]  o_ovf_cnt;
  logic [7:0]  o_udf_cnt;

  int checks = 0;
  int errors = 0;

`ifdef MAC_PACK_SATURATE_EN
  localparam logic [15:0] OVF_POS = 16'h7BFF;
`else
  localparam logic [15:0] OVF_POS = 16'h7C00;
`endif

  mac_result_pack dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_max_exp   (i_max_exp),
    .i_norm_mant (i_norm_mant),
    .i_exp_diff  (i_exp_diff),
    .i_exp_carry (i_exp_carry),
    .i_sign      (i_sign),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow),
    .o_ovf_cnt   (o_ovf_cnt),
    .o_udf_cnt   (o_udf_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [4:0] mexp, input logic [10:0] mant,
                       input logic [4:0] diff, input logic carry, input logic sgn);
    i_valid     = vld;
    i_max_exp   = mexp;
    i_norm_mant = mant;
    i_exp_diff  = diff;
    i_exp_carry = carry;
    i_sign      = sgn;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_ready = 1'b1;
    drive(1'b0, 5'd0, 11'h000, 5'd0, 1'b0, 1'b0);
    #23;
    chk("rst_valid", o_valid, 0);
    chk("rst_result", o_result, 16'h0000);
    chk("rst_flags", {o_overflow, o_underflow}, 0);
    chk("rst_cnts", {o_ovf_cnt, o_udf_cnt}, 0);
    i_rst_n = 1'b1;
    tick();
    chk("idle_ready", o_ready, 1);

    // 1: 1.0
    drive(1'b1, 5'd15, 11'h400, 5'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 11'h000, 5'd0, 1'b0, 1'b0);
    chk("t1_lat1", o_valid, 0);
    tick();
    chk("t1_valid", o_valid, 1);
    chk("t1_result", o_result, 16'h3C00);
    chk("t1_flags", {o_overflow, o_underflow}, 0);
    tick();
    chk("t1_drain", o_valid, 0);

    // 2: exponent 15+4+1 = 20, negative
    drive(1'b1, 5'd15, 11'h7FF, 5'd4, 1'b1, 1'b1);
    tick();
    drive(1'b0, 5'd0, 11'h000, 5'd0, 1'b0, 1'b0);
    tick();
    chk("t2_valid", o_valid, 1);
    chk("t2_result", o_result, 16'hD3FF);
    tick();

    // 3: exponent 32 overflows
    drive(1'b1, 5'd30, 11'h400, 5'd2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 11'h000, 5'd0, 1'b0, 1'b0);
    tick();
    chk("t3_result", o_result, OVF_POS);
    chk("t3_ovf", o_overflow, 1);
    chk("t3_cnt_before", o_ovf_cnt, 0);
    tick();
    chk("t3_cnt_after", o_ovf_cnt, 1);

    // 4: exponent 3-5 = -2 underflows; zero mantissa is not flagged
    drive(1'b1, 5'd3, 11'h400, 5'b11011, 1'b0, 1'b1);
    tick();
    drive(1'b1, 5'd15, 11'h000, 5'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 11'h000, 5'd0, 1'b0, 1'b0);
    chk("t4_udf_result", o_result, 16'h8000);
    chk("t4_udf_flag", {o_overflow, o_underflow}, 2'b01);
    tick();
    chk("t4_zero_valid", o_valid, 1);
    chk("t4_zero_result", o_result, 16'h0000);
    chk("t4_zero_flags", {o_overflow, o_underflow}, 0);
    chk("t4_udf_cnt", o_udf_cnt, 1);
    tick();

    // 5: four beats with downstream stall
    i_ready = 1'b0;
    drive(1'b1, 5'd16, 11'h400, 5'd0, 1'b0, 1'b0);
    tick();
    chk("t5_e1_valid", o_valid, 0);
    chk("t5_e1_ready", o_ready, 1);
    drive(1'b1, 5'd17, 11'h400, 5'd0, 1'b0, 1'b0);
    tick();
    chk("t5_e2_result", o_result, 16'h4000);
    chk("t5_full_ready", o_ready, 0);
    drive(1'b1, 5'd18, 11'h400, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_stall_valid", o_valid, 1);
      chk("t5_stall_result", o_result, 16'h4000);
      chk("t5_stall_ready", o_ready, 0);
    end
    i_ready = 1'b1;
    #1;
    chk("t5_release_ready", o_ready, 1);
    tick();
    chk("t5_beat2", o_result, 16'h4400);
    drive(1'b1, 5'd19, 11'h400, 5'd0, 1'b0, 1'b0);
    tick();
    chk("t5_beat3", o_result, 16'h4800);
    drive(1'b0, 5'd0, 11'h000, 5'd0, 1'b0, 1'b0);
    tick();
    chk("t5_beat4_valid", o_valid, 1);
    chk("t5_beat4", o_result, 16'h4C00);
    tick();
    chk("t5_empty", o_valid, 0);

    // 6: reset with two beats in flight
    drive(1'b1, 5'd30, 11'h400, 5'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 11'h400, 5'b11011, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 11'h000, 5'd0, 1'b0, 1'b0);
    chk("t6_inflight", o_valid, 1);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", o_valid, 0);
    chk("t6_rst_result", o_result, 16'h0000);
    chk("t6_rst_cnts", {o_ovf_cnt, o_udf_cnt}, 0);
    tick();
    i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_beat", o_valid, 0);
    end

    // 300 overflow beats back to back
    drive(1'b1, 5'd31, 11'h400, 5'd1, 1'b1, 1'b1);
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k == 5) begin
        chk("t6_stream_result", o_result, {1'b1, OVF_POS[14:0]});
        chk("t6_stream_ready", o_ready, 1);
      end
      if (k == 101) chk("t6_cnt_mid", o_ovf_cnt, 100);
    end
    drive(1'b0, 5'd0, 11'h000, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    chk("t6_cnt_sat", o_ovf_cnt, 8'hFF);
    chk("t6_udf_zero", o_udf_cnt, 0);
    chk("t6_idle", o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
